// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute control FSM for the accumulator CPU.
// Owns PC and IR; memories use a req/ready handshake so wait states are tolerated.
module cpu_sequencer #(
    parameter int          N        = 16,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_rdata,
    input  logic         imem_ready,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [N-1:0] dmem_addr,
    input  logic         dmem_ready,
    input  logic [N-1:0] off_in,
    input  logic         acc_zero,
    output logic [3:0]   alu_op,
    output logic [1:0]   wb_sel,
    output logic         reg_we,
    output logic [1:0]   reg_dst,
    output logic [1:0]   reg_src,
    output logic [N-1:0] imm_out,
    output logic [N-1:0] pc,
    output logic         halted
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, HALT} state_t;
    localparam logic [N-1:0] ONE = 1;
    state_t         state_q, state_d;
    logic [N-1:0]   pc_q, pc_d, ir_q, ir_d;
    logic [3:0]     op;
    logic [N-1:0]   imm_ext;
    assign op        = ir_q[N-1:N-4];
    assign imm_ext   = {4'b0, ir_q[N-5:0]};
    assign imm_out   = imm_ext;
    assign imem_addr = pc_q;
    assign dmem_addr = imm_ext + off_in;
    assign pc        = pc_q;
    assign halted    = (state_q == HALT);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        reg_dst  = 2'd0;
        reg_src  = 2'd0;
        wb_sel   = 2'd0;
        alu_op   = 4'd0;
        case (state_q)
            IDLE, HALT: state_d = start ? FETCH : state_q;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = (op == 4'd10 || op == 4'd11) ? MEM : (op == 4'd15) ? HALT : EXEC;
            EXEC: begin
                state_d = FETCH;
                pc_d    = (op == 4'd12 || (op == 4'd1 && acc_zero)) ? imm_ext : pc_q + ONE;
                if (op >= 4'd4 && op <= 4'd9) begin
                    reg_we = 1'b1;
                    alu_op = op;
                end else if (op == 4'd2) begin
                    reg_we = 1'b1;
                    wb_sel = 2'd1;
                end else if (op == 4'd3) begin
                    // destination 3 is not a register: MOVE to it is a no-op
                    reg_we  = (ir_q[3:2] != 2'd3);
                    reg_dst = ir_q[3:2];
                    reg_src = ir_q[1:0];
                    wb_sel  = 2'd2;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == 4'd11);
                if (dmem_ready) begin
                    state_d = FETCH;
                    pc_d    = pc_q + ONE;
                    reg_we  = (op == 4'd10);
                    wb_sel  = (op == 4'd10) ? 2'd3 : 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed checks of the sequencer; a second instance starts at
// PC 0xFFFF to exercise PC wrap-around.
module tb_cpu_sequencer;
    logic        clk, rst_n, start, start2;
    logic [15:0] imem_rdata, imem_rdata2, off_in;
    logic        imem_ready, imem_ready2, dmem_ready, acc_zero;
    logic        imem_req, dmem_req, dmem_we, reg_we, halted;
    logic [15:0] imem_addr, dmem_addr, imm_out, pc;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel, reg_dst, reg_src;
    logic        imem_req2, dmem_req2, dmem_we2, reg_we2, halted2;
    logic [15:0] imem_addr2, dmem_addr2, imm_out2, pc2;
    logic [3:0]  alu_op2;
    logic [1:0]  wb_sel2, reg_dst2, reg_src2;
    int checks = 0;
    int errors = 0;

    cpu_sequencer #(.N(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ready(dmem_ready),
        .off_in(off_in), .acc_zero(acc_zero), .alu_op(alu_op), .wb_sel(wb_sel), .reg_we(reg_we),
        .reg_dst(reg_dst), .reg_src(reg_src), .imm_out(imm_out), .pc(pc), .halted(halted)
    );

    cpu_sequencer #(.N(16), .RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .imem_ready(imem_ready2),
        .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_ready(1'b0),
        .off_in(off_in), .acc_zero(acc_zero), .alu_op(alu_op2), .wb_sel(wb_sel2), .reg_we(reg_we2),
        .reg_dst(reg_dst2), .reg_src(reg_src2), .imm_out(imm_out2), .pc(pc2), .halted(halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fetch(input logic [15:0] instr);
        imem_rdata = instr;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({imem_req, dmem_req, dmem_we, reg_we, halted} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b exp 00000", {imem_req, dmem_req, dmem_we, reg_we, halted});
        end
        checks++;
        if ({pc, alu_op, wb_sel} !== 22'h0) begin
            errors++; $display("FAIL reset_pc_op: pc %h alu_op %h wb_sel %h exp all 0", pc, alu_op, wb_sel);
        end
        checks++;
        if (pc2 !== 16'hFFFF) begin
            errors++; $display("FAIL reset_pc2: got %h exp ffff", pc2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_imm;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL idle_no_req: got %b exp 0", imem_req);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            errors++; $display("FAIL imm_fetch: req %b addr %h exp 1 0000", imem_req, imem_addr);
        end
        fetch(16'h2005);
        checks++;
        if ({imem_req, dmem_req, reg_we} !== 3'b000) begin
            errors++; $display("FAIL imm_decode_quiet: got %b exp 000", {imem_req, dmem_req, reg_we});
        end
        @(negedge clk);
        checks++;
        if ({reg_we, wb_sel, reg_dst, imm_out} !== {1'b1, 2'd1, 2'd0, 16'h0005}) begin
            errors++; $display("FAIL imm_exec: we %b wb %d dst %d imm %h exp 1 1 0 0005", reg_we, wb_sel, reg_dst, imm_out);
        end
        @(negedge clk);
        checks++;
        if ({pc, imem_req, reg_we} !== {16'h0001, 1'b1, 1'b0}) begin
            errors++; $display("FAIL imm_next: pc %h req %b we %b exp 0001 1 0", pc, imem_req, reg_we);
        end
    endtask

    task automatic test_add;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, 16'h0001}) begin
                errors++; $display("FAIL fetch_wait_%0d: req %b addr %h exp 1 0001", i, imem_req, imem_addr);
            end
        end
        fetch(16'h4000);
        checks++;
        if ({reg_we, alu_op} !== 5'h00) begin
            errors++; $display("FAIL add_decode: we %b alu_op %h exp 0 0", reg_we, alu_op);
        end
        @(negedge clk);
        checks++;
        if ({reg_we, alu_op, wb_sel, reg_dst} !== {1'b1, 4'd4, 2'd0, 2'd0}) begin
            errors++; $display("FAIL add_exec: we %b op %h wb %d dst %d exp 1 4 0 0", reg_we, alu_op, wb_sel, reg_dst);
        end
        @(negedge clk);
        checks++;
        if ({reg_we, alu_op, pc} !== {1'b0, 4'd0, 16'h0002}) begin
            errors++; $display("FAIL add_one_cycle: we %b op %h pc %h exp 0 0 0002", reg_we, alu_op, pc);
        end
    endtask

    task automatic test_move;
        start = 1'b1;
        imem_rdata = 16'h3006;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_rdata = 16'hF000;
        checks++;
        if ({imem_req, reg_we} !== 2'b00) begin
            errors++; $display("FAIL move_decode: req %b we %b exp 0 0", imem_req, reg_we);
        end
        @(negedge clk);
        imem_ready = 1'b0;
        checks++;
        if ({reg_we, reg_dst, reg_src, wb_sel, halted} !== {1'b1, 2'd1, 2'd2, 2'd2, 1'b0}) begin
            errors++; $display("FAIL move_exec: we %b dst %d src %d wb %d halted %b exp 1 1 2 2 0", reg_we, reg_dst, reg_src, wb_sel, halted);
        end
        @(negedge clk);
        checks++;
        if ({pc, imem_req} !== {16'h0003, 1'b1}) begin
            errors++; $display("FAIL move_next: pc %h req %b exp 0003 1", pc, imem_req);
        end
        fetch(16'h300C);
        @(negedge clk);
        checks++;
        if ({reg_we, reg_dst, wb_sel} !== {1'b0, 2'd3, 2'd2}) begin
            errors++; $display("FAIL move_dst3: we %b dst %d wb %d exp 0 3 2", reg_we, reg_dst, wb_sel);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (pc !== 16'h0004) begin
            errors++; $display("FAIL move_dst3_pc: got %h exp 0004", pc);
        end
    endtask

    task automatic test_store;
        off_in = 16'h0100;
        fetch(16'hB010);
        checks++;
        if (dmem_req !== 1'b0) begin
            errors++; $display("FAIL store_decode: dmem_req %b exp 0", dmem_req);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({dmem_req, dmem_we, dmem_addr, imem_req, reg_we, pc} !== {1'b1, 1'b1, 16'h0110, 1'b0, 1'b0, 16'h0004}) begin
                errors++; $display("FAIL store_hold_%0d: req %b we %b addr %h ireq %b rwe %b pc %h exp 1 1 0110 0 0 0004",
                                   i, dmem_req, dmem_we, dmem_addr, imem_req, reg_we, pc);
            end
            if (i == 3) dmem_ready = 1'b1;
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        checks++;
        if ({dmem_req, imem_req, pc} !== {1'b0, 1'b1, 16'h0005}) begin
            errors++; $display("FAIL store_done: dreq %b ireq %b pc %h exp 0 1 0005", dmem_req, imem_req, pc);
        end
    endtask

    task automatic test_load;
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        checks++;
        if ({imem_req, dmem_req, reg_we, pc} !== {1'b1, 1'b0, 1'b0, 16'h0005}) begin
            errors++; $display("FAIL dready_ignored: ireq %b dreq %b we %b pc %h exp 1 0 0 0005", imem_req, dmem_req, reg_we, pc);
        end
        off_in = 16'hFF02;
        fetch(16'hA0FF);
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, reg_we} !== {1'b1, 1'b0, 16'h0001, 1'b0}) begin
            errors++; $display("FAIL load_wait: req %b we %b addr %h rwe %b exp 1 0 0001 0", dmem_req, dmem_we, dmem_addr, reg_we);
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if ({reg_we, wb_sel, reg_dst} !== {1'b1, 2'd3, 2'd0}) begin
            errors++; $display("FAIL load_wb: we %b wb %d dst %d exp 1 3 0", reg_we, wb_sel, reg_dst);
        end
        @(negedge clk);
        dmem_ready = 1'b0;
        checks++;
        if ({reg_we, dmem_req, pc} !== {1'b0, 1'b0, 16'h0006}) begin
            errors++; $display("FAIL load_done: we %b dreq %b pc %h exp 0 0 0006", reg_we, dmem_req, pc);
        end
    endtask

    task automatic test_jumps;
        acc_zero = 1'b1;
        fetch(16'h1020);
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b0) begin
            errors++; $display("FAIL ifjump_no_write: got %b exp 0", reg_we);
        end
        @(negedge clk);
        checks++;
        if (pc !== 16'h0020) begin
            errors++; $display("FAIL ifjump_taken: pc %h exp 0020", pc);
        end
        acc_zero = 1'b0;
        fetch(16'h1040);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pc !== 16'h0021) begin
            errors++; $display("FAIL ifjump_not_taken: pc %h exp 0021", pc);
        end
        fetch(16'hC123);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pc !== 16'h0123) begin
            errors++; $display("FAIL jump: pc %h exp 0123", pc);
        end
    endtask

    task automatic test_wrap;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        checks++;
        if ({imem_req2, imem_addr2} !== {1'b1, 16'hFFFF}) begin
            errors++; $display("FAIL wrap_fetch: req %b addr %h exp 1 ffff", imem_req2, imem_addr2);
        end
        imem_rdata2 = 16'h0000;
        imem_ready2 = 1'b1;
        @(negedge clk);
        imem_ready2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({pc2, imem_req2} !== {16'h0000, 1'b1}) begin
            errors++; $display("FAIL pc_wrap: pc %h req %b exp 0000 1", pc2, imem_req2);
        end
    endtask

    task automatic test_halt;
        fetch(16'hF000);
        @(negedge clk);
        checks++;
        if ({halted, imem_req, dmem_req, pc} !== {1'b1, 1'b0, 1'b0, 16'h0123}) begin
            errors++; $display("FAIL halt_enter: halted %b ireq %b dreq %b pc %h exp 1 0 0 0123", halted, imem_req, dmem_req, pc);
        end
        imem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem_ready = 1'b0;
        checks++;
        if ({halted, imem_req, pc} !== {1'b1, 1'b0, 16'h0123}) begin
            errors++; $display("FAIL halt_stay: halted %b ireq %b pc %h exp 1 0 0123", halted, imem_req, pc);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0123}) begin
            errors++; $display("FAIL halt_resume: halted %b ireq %b addr %h exp 0 1 0123", halted, imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_in_mem;
        off_in = 16'h0000;
        fetch(16'hA005);
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_addr} !== {1'b1, 16'h0005}) begin
            errors++; $display("FAIL mem_before_reset: req %b addr %h exp 1 0005", dmem_req, dmem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req, imem_req, pc, halted} !== {1'b0, 1'b0, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL async_reset: dreq %b ireq %b pc %h halted %b exp 0 0 0000 0", dmem_req, imem_req, pc, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({imem_req, dmem_req, pc, pc2} !== {1'b0, 1'b0, 16'h0000, 16'hFFFF}) begin
            errors++; $display("FAIL reset_idle: ireq %b dreq %b pc %h pc2 %h exp 0 0 0000 ffff", imem_req, dmem_req, pc, pc2);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        imem_rdata = '0; imem_ready = 1'b0; imem_rdata2 = '0; imem_ready2 = 1'b0;
        dmem_ready = 1'b0; off_in = '0; acc_zero = 1'b0;
        test_reset;
        test_imm;
        test_add;
        test_move;
        test_store;
        test_load;
        test_jumps;
        test_wrap;
        test_halt;
        test_reset_in_mem;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
